load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit between the core datapath and the data bus. It replaces the purely combinational byte-enable steering with a handshaked, multi-cycle access engine. It accepts one RV32/RV64 load or store per request, checks alignment and funct3 legality, and drives a valid/ack bus with lane-steered write data and byte enables. It returns sign- or zero-extended load data or an error code. The core stalls on `req_ready` low.

## Interface
Parameters:
- `DATA_W`, 32: bus/register width; legal values 32 or 64. 64 enables LD/SD/LWU.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 255: maximum cycles `bus_req` stays high without `bus_ack` before a bus error is raised. Legal range 1..65535.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: core request.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 of the memory instruction.
- `req_addr` in ADDR_W: effective address.
- `req_wdata` in DATA_W: store source (rs2).
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `rsp_err` out 2: 0 = OK, 1 = MISALIGNED, 2 = ILLEGAL, 3 = BUS_TIMEOUT.
- `bus_req` out 1: bus access valid.
- `bus_we` out 1: bus write.
- `bus_addr` out ADDR_W: `req_addr` with the low log2(DATA_W/8) bits zeroed.
- `bus_be` out DATA_W/8: byte enables.
- `bus_wdata` out DATA_W: lane-steered write data.
- `bus_ack` in 1: access complete; `bus_rdata` is valid in the same cycle.
- `bus_rdata` in DATA_W: read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On accept, the unit latches we/funct3/addr/wdata.
  - Illegal or misaligned request: go to RESP with the error set. No bus cycle is issued.
  - Otherwise: go to ACCESS.
- ACCESS: `bus_req`=1. `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are held stable from the latched request.
  - On `bus_ack`: register `bus_rdata` and go to RESP with err=OK.
  - If `TIMEOUT` cycles elapse without ack: drop `bus_req` and go to RESP with err=BUS_TIMEOUT.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. With DATA_W=64, also 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW. With DATA_W=64, also 011 SD.
  - All other combinations are ILLEGAL. ILLEGAL is checked before MISALIGNED.
- Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0. Bytes are always aligned.
- Lane offset: `off` = addr[log2(DATA_W/8)-1:0].
  - `bus_be` = size mask shifted left by `off`.
  - `bus_wdata` = low size bytes of wdata shifted left by 8*off. All other bytes are 0.
- Loads: `bus_be` is driven as for a store of the same size. Extraction is `bus_rdata >> 8*off`, truncated to size, then sign- or zero-extended to DATA_W.
- Counter: it clears on entry to ACCESS and saturates; no wrap-around.
- `bus_req` is never asserted outside ACCESS.
- `bus_ack` arriving outside ACCESS is ignored.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, counter 0.
- Accept at cycle N. `bus_req` rises at N+1. Ack at N+k (k≥1). `rsp_valid` at N+k+1. `req_ready` is high again at N+k+2.
  - Minimum latency, accept to response, is 2 cycles.
  - Back-to-back throughput is one access per 3 cycles.
- Error path: accept at N, `rsp_valid` at N+1, no bus activity.
- Timeout: `bus_req` high for exactly `TIMEOUT` cycles, N+1..N+TIMEOUT. `rsp_valid` with err=3 follows in the next cycle.
- Ack in the same cycle that the timeout is reached: the ack wins, err=OK.
- Reset asserted mid-ACCESS: `bus_req` drops immediately (asynchronously). The response is discarded.
- All outputs are registered; no combinational path from `bus_ack` to any output.

## Structure
- `lsu_pkg` holds:
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`.
  - the `lsu_err_e` enum (OK/MISALIGNED/ILLEGAL/BUS_TIMEOUT).
  - the `lsu_state_e` enum.
- Sub-module `lsu_lane_align`, combinational and parametrised by DATA_W. It maps (funct3, off, wdata, rdata) to (be, steered wdata, extended rdata), plus the legality and alignment flags. The top level holds the FSM, the request latch and the timeout counter.

## Test plan
- SB, DATA_W=32, addr=0x1003, wdata=0x11223344, ack after 2 cycles -> `bus_addr`=0x1000, `bus_be`=1000, `bus_wdata`=0x44000000, `rsp_valid` at accept+3, err=0.
- LH at addr=0x2002, `bus_rdata`=0x8001_7F00, immediate ack -> `rsp_rdata`=0xFFFF8001. The same case with LHU -> 0x00008001.
- LW at addr=0x0006 -> `rsp_valid` at accept+1, err=1, `bus_req` never asserted.
- SD with DATA_W=32 -> err=2. With DATA_W=64, SD at addr=0x10 -> `bus_be`=0xFF.
- TIMEOUT=4, no ack -> `bus_req` high for exactly 4 cycles, then err=3. A following request proceeds normally.
- Reset asserted in the second ACCESS cycle -> `bus_req`=0 in the same cycle, no `rsp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, error codes
// and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Width of the bus-timeout counter; covers the full TIMEOUT range.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    OK          = 2'd0,
    MISALIGNED  = 2'd1,
    ILLEGAL     = 2'd2,
    BUS_TIMEOUT = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data placement, load-data
// extraction/extension, plus funct3 legality and natural-alignment flags.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              legal,
  output logic              aligned
);

  localparam logic WIDE = (DATA_W == 64);

  logic [BE_W-1:0]   size_mask;
  logic [2:0]        align_mask;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] rdata_shift;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_D:             legal = WIDE;
      F3_BU, F3_HU:     legal = !we;
      F3_WU:            legal = !we && WIDE;
      default:          legal = 1'b0;
    endcase
  end

  always_comb begin
    size_mask  = '1;
    align_mask = 3'd7;
    case (funct3[1:0])
      2'd0: begin size_mask = BE_W'(1);  align_mask = 3'd0; end
      2'd1: begin size_mask = BE_W'(3);  align_mask = 3'd1; end
      2'd2: begin size_mask = BE_W'(15); align_mask = 3'd3; end
      default: begin size_mask = '1;     align_mask = 3'd7; end
    endcase
  end

  assign aligned = (off & OFF_W'(align_mask)) == '0;
  assign be      = size_mask << off;

  always_comb begin
    data_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      data_mask[8*i +: 8] = {8{size_mask[i]}};
    end
  end

  assign wdata_lane  = (wdata & data_mask) << {off, 3'b000};
  assign rdata_shift = rdata >> {off, 3'b000};

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  always_comb begin
    rdata_ext = rdata_shift;
    case (funct3)
      F3_B:    rdata_ext = DATA_W'($signed(rdata_shift[7:0]));
      F3_BU:   rdata_ext = DATA_W'(rdata_shift[7:0]);
      F3_H:    rdata_ext = DATA_W'($signed(rdata_shift[15:0]));
      F3_HU:   rdata_ext = DATA_W'(rdata_shift[15:0]);
      F3_W:    rdata_ext = DATA_W'($signed(rdata_shift[31:0]));
      F3_WU:   rdata_ext = DATA_W'(rdata_shift[31:0]);
      default: rdata_ext = rdata_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked load/store engine: accepts one request, checks it, runs a
// valid/ack bus cycle with timeout, and returns one registered response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int  DATA_W  = 32,
  parameter int  ADDR_W  = 32,
  parameter int  TIMEOUT = 255,
  localparam int BE_W    = DATA_W / 8,
  localparam int OFF_W   = $clog2(BE_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_e state_q, next_state;

  logic             we_q;
  logic [2:0]       f3_q;
  logic [OFF_W-1:0] off_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  lsu_err_e          rsp_err_q, rsp_err_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [BE_W-1:0]   bus_be_q, bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic              in_idle, accept, timed_out;
  logic              a_we;
  logic [2:0]        a_f3;
  logic [OFF_W-1:0]  a_off;
  logic [BE_W-1:0]   a_be;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              a_legal, a_aligned;

  assign in_idle   = (state_q == IDLE);
  assign accept    = req_valid && in_idle;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // One aligner serves both phases: the live request while idle (legality,
  // lanes) and the latched request afterwards (load extraction).
  assign a_we  = in_idle ? req_we                 : we_q;
  assign a_f3  = in_idle ? req_funct3             : f3_q;
  assign a_off = in_idle ? req_addr[OFF_W-1:0]    : off_q;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .we         (a_we),
    .funct3     (a_f3),
    .off        (a_off),
    .wdata      (req_wdata),
    .rdata      (bus_rdata),
    .be         (a_be),
    .wdata_lane (a_wdata),
    .rdata_ext  (a_rdata),
    .legal      (a_legal),
    .aligned    (a_aligned)
  );

  // State register plus all registered outputs and the request latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= OK;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= next_state;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      if (accept) begin
        we_q  <= req_we;
        f3_q  <= req_funct3;
        off_q <= req_addr[OFF_W-1:0];
      end
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (accept) next_state = (a_legal && a_aligned) ? ACCESS : RESP;
      ACCESS:  if (bus_ack || timed_out) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead from next_state and then registered,
  // so bus_ack never reaches a port combinationally.
  always_comb begin
    req_ready_d = (next_state == IDLE);
    rsp_valid_d = (next_state == RESP);
    bus_req_d   = (next_state == ACCESS);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_rdata_d = '0;
          if (!a_legal)        rsp_err_d = ILLEGAL;
          else if (!a_aligned) rsp_err_d = MISALIGNED;
          else                 rsp_err_d = OK;
          bus_we_d    = req_we;
          bus_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          bus_be_d    = a_be;
          bus_wdata_d = a_wdata;
          cnt_d       = '0;
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          rsp_rdata_d = we_q ? '0 : a_rdata;
          rsp_err_d   = OK;
        end else if (timed_out) begin
          rsp_err_d   = BUS_TIMEOUT;
        end else if (cnt_q != '1) begin
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (next_state != ACCESS) begin
      bus_we_d    = 1'b0;
      bus_addr_d  = '0;
      bus_be_d    = '0;
      bus_wdata_d = '0;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=6)
// instance, directed cases then random traffic against a byte-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, bus_ack;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rdata;

  logic        r32_ready, r32_rsp_valid, r32_bus_req, r32_bus_we;
  logic [31:0] r32_rdata, r32_addr, r32_wdata;
  logic [1:0]  r32_err;
  logic [3:0]  r32_be;
  logic        r64_ready, r64_rsp_valid, r64_bus_req, r64_bus_we;
  logic [63:0] r64_rdata, r64_wdata;
  logic [31:0] r64_addr;
  logic [1:0]  r64_err;
  logic [7:0]  r64_be;

  logic        o_ready, o_rsp_valid, o_bus_req, o_bus_we;
  logic [1:0]  o_err;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(r32_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(r32_rsp_valid), .rsp_rdata(r32_rdata), .rsp_err(r32_err),
    .bus_req(r32_bus_req), .bus_we(r32_bus_we), .bus_addr(r32_addr),
    .bus_be(r32_be), .bus_wdata(r32_wdata),
    .bus_ack(bus_ack && !sel), .bus_rdata(bus_rdata[31:0])
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(6)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(r64_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r64_rsp_valid), .rsp_rdata(r64_rdata), .rsp_err(r64_err),
    .bus_req(r64_bus_req), .bus_we(r64_bus_we), .bus_addr(r64_addr),
    .bus_be(r64_be), .bus_wdata(r64_wdata),
    .bus_ack(bus_ack && sel), .bus_rdata(bus_rdata)
  );

  always_comb begin
    if (sel) begin
      o_ready = r64_ready; o_rsp_valid = r64_rsp_valid; o_bus_req = r64_bus_req;
      o_bus_we = r64_bus_we; o_err = r64_err; o_rdata = r64_rdata;
      o_wdata = r64_wdata; o_addr = r64_addr; o_be = r64_be;
    end else begin
      o_ready = r32_ready; o_rsp_valid = r32_rsp_valid; o_bus_req = r32_bus_req;
      o_bus_we = r32_bus_we; o_err = r32_err; o_rdata = {32'b0, r32_rdata};
      o_wdata = {32'b0, r32_wdata}; o_addr = r32_addr; o_be = {4'b0, r32_be};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, byte offset in the bus word, masks built
  // with wide arithmetic so the 8-byte case does not overflow.
  function automatic void model(input bit s, input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [63:0] wd,
                                input logic [63:0] rd, output int err,
                                output logic [63:0] be, output logic [63:0] wdo,
                                output logic [63:0] rdo);
    int wb, size, off;
    bit legal;
    logic [127:0] m, wm, v;
    wb   = s ? 8 : 4;
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]) % wb;
    if (we) legal = (f3 <= 3'd2) || (s && f3 == 3'd3);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (s && f3 inside {3'd3, 3'd6});
    err = !legal ? 2 : ((off % size) != 0) ? 1 : 0;
    wm  = s ? {64'b0, {64{1'b1}}} : 128'hFFFF_FFFF;
    m   = (128'd1 << (8 * size)) - 128'd1;
    be  = 64'(((128'd1 << size) - 128'd1) << off);
    wdo = 64'(((128'(wd) & m) << (8 * off)) & wm);
    v   = ((128'(rd) & wm) >> (8 * off)) & m;
    if (!f3[2] && v[8*size-1]) v = v | ~m;
    rdo = we ? 64'd0 : 64'(v & wm);
  endfunction

  // ack_dly = k acks in the k-th ACCESS cycle; <= 0 never acks.
  task automatic run_op(input bit s, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, input int ack_dly);
    int e, tmo;
    bit acked;
    logic [63:0] be, wdo, rdo;
    logic [31:0] exp_addr;
    model(s, we, f3, addr, wd, rd, e, be, wdo, rdo);
    tmo      = s ? 6 : 4;
    exp_addr = addr & ~(s ? 32'd7 : 32'd3);
    acked    = 1'b0;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = s ? wd : {32'hDEAD_BEEF, wd[31:0]};
    #1 check("ready_before", 64'(o_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_wdata = {$urandom, $urandom};
    if (e != 0) begin
      check("err_rsp_valid", 64'(o_rsp_valid), 64'd1);
      check("err_code", 64'(o_err), 64'(e));
      check("err_rdata", o_rdata, 64'd0);
      check("err_bus_req", 64'(o_bus_req), 64'd0);
      @(negedge clk);
      check("err_rsp_done", 64'(o_rsp_valid), 64'd0);
      check("err_bus_req2", 64'(o_bus_req), 64'd0);
      check("err_ready", 64'(o_ready), 64'd1);
      return;
    end
    for (int i = 1; i <= tmo; i++) begin
      check("bus_req", 64'(o_bus_req), 64'd1);
      check("bus_we", 64'(o_bus_we), 64'(we));
      check("bus_addr", 64'(o_addr), 64'(exp_addr));
      check("bus_be", 64'(o_be), be);
      check("bus_wdata", o_wdata, wdo);
      check("rsp_idle", 64'(o_rsp_valid), 64'd0);
      check("ready_busy", 64'(o_ready), 64'd0);
      if (ack_dly == i) begin
        bus_ack = 1'b1; bus_rdata = rd; acked = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = {$urandom, $urandom};
        break;
      end
      bus_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    check("rsp_valid", 64'(o_rsp_valid), 64'd1);
    check("rsp_bus_req", 64'(o_bus_req), 64'd0);
    check("rsp_err", 64'(o_err), acked ? 64'd0 : 64'd3);
    check("rsp_rdata", o_rdata, acked ? rdo : 64'd0);
    @(negedge clk);
    check("rsp_pulse", 64'(o_rsp_valid), 64'd0);
    check("ready_after", 64'(o_ready), 64'd1);
  endtask

  task automatic check_reset_state(input bit s);
    sel = s;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_bus_req", 64'(o_bus_req), 64'd0);
    check("rst_bus_we", 64'(o_bus_we), 64'd0);
    check("rst_bus_addr", 64'(o_addr), 64'd0);
    check("rst_bus_be", 64'(o_be), 64'd0);
    check("rst_bus_wdata", o_wdata, 64'd0);
  endtask

  initial begin
    bit s, we;
    logic [2:0] f3;
    logic [31:0] addr;
    int r, ack;

    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_state(1'b0);
    check_reset_state(1'b1);
    @(negedge clk);
    reset = 1'b0;

    // SB to the top lane, ack in the second access cycle
    run_op(1'b0, 1'b1, 3'b000, 32'h1003, 64'h1122_3344, 64'h0, 2);
    // LH / LHU of the upper halfword, immediate ack
    run_op(1'b0, 1'b0, 3'b001, 32'h2002, 64'h0, 64'h8001_7F00, 1);
    run_op(1'b0, 1'b0, 3'b101, 32'h2002, 64'h0, 64'h8001_7F00, 1);
    // Misaligned LW, illegal SD on 32-bit, SD and LD on 64-bit
    run_op(1'b0, 1'b0, 3'b010, 32'h0006, 64'h0, 64'h0, 1);
    run_op(1'b0, 1'b1, 3'b011, 32'h0010, 64'h55, 64'h0, 1);
    run_op(1'b1, 1'b1, 3'b011, 32'h0010, 64'h0102_0304_0506_0708, 64'h0, 1);
    run_op(1'b1, 1'b0, 3'b011, 32'h0008, 64'h0, 64'hF00D_CAFE_1234_5678, 3);
    // Illegal encodings take priority over misalignment
    run_op(1'b0, 1'b0, 3'b111, 32'h0003, 64'h0, 64'h0, 1);
    run_op(1'b0, 1'b1, 3'b101, 32'h0001, 64'h0, 64'h0, 1);
    run_op(1'b0, 1'b0, 3'b110, 32'h0000, 64'h0, 64'h0, 1);
    // LWU / LW from the upper word of a 64-bit bus
    run_op(1'b1, 1'b0, 3'b110, 32'h0104, 64'h0, 64'h9ABC_DEF0_1111_2222, 2);
    run_op(1'b1, 1'b0, 3'b010, 32'h0104, 64'h0, 64'h9ABC_DEF0_1111_2222, 1);
    // Timeout, then a normal access; then ack exactly at the timeout cycle
    run_op(1'b0, 1'b0, 3'b010, 32'h0100, 64'h0, 64'h0, 0);
    run_op(1'b0, 1'b1, 3'b010, 32'h0104, 64'hCAFE_BABE, 64'h0, 1);
    run_op(1'b0, 1'b0, 3'b000, 32'h0101, 64'h0, 64'h0000_8000, 4);
    run_op(1'b1, 1'b0, 3'b011, 32'h0200, 64'h0, 64'h0, 0);

    // Stray ack while idle is ignored
    @(negedge clk);
    sel = 1'b0; bus_ack = 1'b1; bus_rdata = 64'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("stray_rsp", 64'(o_rsp_valid), 64'd0);
    check("stray_bus_req", 64'(o_bus_req), 64'd0);
    check("stray_ready", 64'(o_ready), 64'd1);

    // Reset during the second access cycle
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_bus_req1", 64'(o_bus_req), 64'd1);
    @(negedge clk);
    check("mid_bus_req2", 64'(o_bus_req), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_bus_req", 64'(o_bus_req), 64'd0);
    check("mid_rst_rsp", 64'(o_rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rsp", 64'(o_rsp_valid), 64'd0);
      check("post_rst_ready", 64'(o_ready), 64'd1);
    end
    run_op(1'b0, 1'b0, 3'b100, 32'h0042, 64'h0, 64'h00AB_0000, 1);

    // Random traffic across both widths
    for (int n = 0; n < 80; n++) begin
      s    = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      r    = int'($urandom_range(0, 7));
      ack  = (r == 0) ? 0 : 1 + (r % 3);
      run_op(s, we, f3, addr, {$urandom, $urandom}, {$urandom, $urandom}, ack);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
